// File: rtl/dual_port_ram_fifo_ctrl.sv
// dual_port_ram_fifo_ctrl
// FIFO controller for a 64x8 dual-port RAM with a 1-cycle registered read.
// Port A of the RAM is the write port and port B is the read port.
// Words are accepted on a valid/ready input stream and returned in FIFO order
// on a registered valid/ready output stream. A pending-read flag and a
// 2-entry output buffer hide the RAM read latency, so the controller sustains
// one word per cycle.
// Optional feature: define RAM_FIFO_WATERMARK_EN to add a registered
// almost_full output that is set while level >= AF_THRESH.
module dual_port_ram_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6
`ifdef RAM_FIFO_WATERMARK_EN
    ,
    parameter int AF_THRESH = 56
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] level,
`ifdef RAM_FIFO_WATERMARK_EN
    output logic              almost_full,
`endif
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    // Registered state
    logic [ADDR_W-1:0] wr_ptr_reg,  wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg,  rd_ptr_next;
    logic [ADDR_W:0]   mem_cnt_reg, mem_cnt_next;
    logic              pend_reg,    pend_next;
    logic [1:0]        buf_cnt_reg, buf_cnt_next;
    logic [DATA_W-1:0] head_reg,    head_next;
    logic [DATA_W-1:0] skid_reg,    skid_next;

    // Handshake and issue qualifiers
    logic       push;
    logic       pop;
    logic       issue;
    logic [1:0] occ_after_pop;
    logic [1:0] buf_after_pop;

    assign in_ready   = (mem_cnt_reg != CNT_FULL);
    assign out_valid  = (buf_cnt_reg != 2'd0);
    assign out_data   = head_reg;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    // Port A writes the incoming word at wr_ptr in the same cycle it is accepted.
    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_reg;
    assign ram_data_a = in_data;

    // Port B only reads; its address always follows rd_ptr.
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr_reg;
    assign ram_data_b = '0;

    // Words in flight plus buffered, after this cycle's pop. Never exceeds 2.
    assign occ_after_pop = {1'b0, pend_reg} + buf_cnt_reg - {1'b0, pop};
    assign buf_after_pop = buf_cnt_reg - {1'b0, pop};
    // Issue is blocked while the RAM is empty, so a read never targets the
    // address port A is writing in the same cycle.
    assign issue = (mem_cnt_reg != '0) && (occ_after_pop < 2'd2);

    assign level = (ADDR_W+2)'(mem_cnt_reg) + (ADDR_W+2)'(pend_reg)
                 + (ADDR_W+2)'(buf_cnt_reg);

    // Next-state: pointers, RAM count, pending read and output buffer shuffle.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        mem_cnt_next = mem_cnt_reg;
        head_next    = head_reg;
        skid_next    = skid_reg;
        pend_next    = issue;
        buf_cnt_next = buf_after_pop + {1'b0, pend_reg};

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (issue) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push && !issue) begin
            mem_cnt_next = mem_cnt_reg + CNT_ONE;
        end else if (!push && issue) begin
            mem_cnt_next = mem_cnt_reg - CNT_ONE;
        end

        // Popping promotes the skid entry; a returning RAM word lands in the
        // first free slot behind whatever remains.
        if (pop) begin
            head_next = skid_reg;
        end
        if (pend_reg) begin
            if (buf_after_pop == 2'd0) begin
                head_next = ram_q_b;
            end else begin
                skid_next = ram_q_b;
            end
        end
    end

    // State register with synchronous active-low reset; RAM contents untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            mem_cnt_reg <= '0;
            pend_reg    <= 1'b0;
            buf_cnt_reg <= 2'd0;
            head_reg    <= '0;
            skid_reg    <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            mem_cnt_reg <= mem_cnt_next;
            pend_reg    <= pend_next;
            buf_cnt_reg <= buf_cnt_next;
            head_reg    <= head_next;
            skid_reg    <= skid_next;
        end
    end

`ifdef RAM_FIFO_WATERMARK_EN
    localparam logic [ADDR_W+1:0] AF_LEVEL = (ADDR_W+2)'(AF_THRESH);

    logic [ADDR_W+1:0] level_next;
    logic              almost_full_reg;

    // Computed from the next level so the flag lines up with level itself.
    assign level_next = (ADDR_W+2)'(mem_cnt_next) + (ADDR_W+2)'(pend_next)
                      + (ADDR_W+2)'(buf_cnt_next);
    assign almost_full = almost_full_reg;

    // Registered watermark flag, cleared in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (level_next >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_dual_port_ram_fifo_ctrl.sv
// tb_dual_port_ram_fifo_ctrl
// Directed bench for dual_port_ram_fifo_ctrl with a behavioural 64x8 RAM
// (registered read on port B). Define RAM_FIFO_WATERMARK_EN to include the
// almost_full scenario.
module tb_dual_port_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] level;
`ifdef RAM_FIFO_WATERMARK_EN
    logic       almost_full;
`endif
    logic       ram_we_a;
    logic [5:0] ram_addr_a;
    logic [7:0] ram_data_a;
    logic       ram_we_b;
    logic [5:0] ram_addr_b;
    logic [7:0] ram_data_b;
    logic [7:0] ram_q_b;

    int vectors;
    int miscompares;

    dual_port_ram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
`ifdef RAM_FIFO_WATERMARK_EN
        .almost_full(almost_full),
`endif
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_q_b    (ram_q_b)
    );

    // Behavioural dual-port RAM, one-cycle registered read on port B
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_b <= mem[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b expected 0", out_valid); miscompares++;
        end
        vectors++;
        if (out_data !== 8'h00) begin
            $display("FAIL reset_out_data: got %h expected 00", out_data); miscompares++;
        end
        vectors++;
        if (level !== 8'd0) begin
            $display("FAIL reset_level: got %0d expected 0", level); miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready); miscompares++;
        end
        vectors++;
        if (ram_we_b !== 1'b0 || ram_we_a !== 1'b0) begin
            $display("FAIL reset_ram_we: got we_a=%b we_b=%b expected 0 0", ram_we_a, ram_we_b); miscompares++;
        end
`ifdef RAM_FIFO_WATERMARK_EN
        vectors++;
        if (almost_full !== 1'b0) begin
            $display("FAIL reset_almost_full: got %b expected 0", almost_full); miscompares++;
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_fall_through();
        apply_reset();
        // cycle 0: push A5
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        vectors++;
        if (level !== 8'd0) begin
            $display("FAIL ft_level_c0: got %0d expected 0", level); miscompares++;
        end
        tick(); // cycle 1
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd1) begin
            $display("FAIL ft_c1: got valid=%b level=%0d expected valid=0 level=1", out_valid, level); miscompares++;
        end
        tick(); // cycle 2
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd1) begin
            $display("FAIL ft_c2: got valid=%b level=%0d expected valid=0 level=1", out_valid, level); miscompares++;
        end
        tick(); // cycle 3
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 8'd1) begin
            $display("FAIL ft_c3: got valid=%b data=%h level=%0d expected valid=1 data=a5 level=1",
                     out_valid, out_data, level); miscompares++;
        end
        $display("pop word %h at cycle 3", out_data);
        tick(); // cycle 4
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd0) begin
            $display("FAIL ft_c4: got valid=%b level=%0d expected valid=0 level=0", out_valid, level); miscompares++;
        end
        $display("test_fall_through done");
    endtask

    task automatic test_fill_drain();
        int k;
        apply_reset();
        out_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            if (!in_ready) break;
            tick();
            k++;
        end
        vectors++;
        if (k !== 66) begin
            $display("FAIL fill_count: got %0d accepted expected 66", k); miscompares++;
        end
        vectors++;
        if (level !== 8'd66 || in_ready !== 1'b0) begin
            $display("FAIL fill_full: got level=%0d in_ready=%b expected 66 0", level, in_ready); miscompares++;
        end
        tick(); // hold in_valid with no room: nothing must be accepted
        vectors++;
        if (level !== 8'd66 || in_ready !== 1'b0) begin
            $display("FAIL fill_hold: got level=%0d in_ready=%b expected 66 0", level, in_ready); miscompares++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 66; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                $display("FAIL drain_word: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, 8'(i));
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    $display("FAIL drain_ready_c0: got %b expected 0", in_ready); miscompares++;
                end
            end
            if (i == 1) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    $display("FAIL drain_ready_c1: got %b expected 1", in_ready); miscompares++;
                end
            end
            $display("pop word %h", out_data);
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd0) begin
            $display("FAIL drain_empty: got valid=%b level=%0d expected 0 0", out_valid, level); miscompares++;
        end
        out_ready = 1'b0;
        $display("test_fill_drain done");
    endtask

    task automatic test_back_to_back();
        int k;
        int expn;
        int gaps;
        bit started;
        bit acc;
        apply_reset();
        out_ready = 1'b1;
        k = 0; expn = 0; gaps = 0; started = 1'b0;
        for (int cyc = 0; cyc < 400 && expn < 200; cyc++) begin
            in_valid = (k < 200);
            in_data  = 8'(k);
            acc = in_valid && in_ready;
            if (out_valid) begin
                vectors++;
                if (out_data !== 8'(expn)) begin
                    $display("FAIL stream_word: got %h expected %h", out_data, 8'(expn)); miscompares++;
                end
                expn++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        vectors++;
        if (expn !== 200) begin
            $display("FAIL stream_count: got %0d words expected 200", expn); miscompares++;
        end
        vectors++;
        if (gaps !== 0) begin
            $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps); miscompares++;
        end
        $display("test_back_to_back done: %0d words", expn);
    endtask

    task automatic test_random_stalls();
        logic [7:0] sb [$];
        logic [7:0] expd;
        logic [7:0] hold_data;
        bit hold_valid;
        apply_reset();
        hold_valid = 1'b0;
        hold_data  = 8'h00;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            vectors++;
            if (level !== 8'(sb.size())) begin
                $display("FAIL rand_level: got %0d expected %0d", level, sb.size()); miscompares++;
            end
            if (level < 8'd64) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    $display("FAIL rand_in_ready: got %b expected 1 at level %0d", in_ready, level); miscompares++;
                end
            end
            if (hold_valid) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== hold_data) begin
                    $display("FAIL rand_stall_stable: got valid=%b data=%h expected valid=1 data=%h",
                             out_valid, out_data, hold_data); miscompares++;
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_extra_word: got %h expected no word", out_data); miscompares++;
                end else begin
                    expd = sb.pop_front();
                    if (out_data !== expd) begin
                        $display("FAIL rand_word: got %h expected %h", out_data, expd); miscompares++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (sb.size() != 0 || out_valid); cyc++) begin
            if (out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_drain_extra: got %h expected no word", out_data); miscompares++;
                end else begin
                    expd = sb.pop_front();
                    if (out_data !== expd) begin
                        $display("FAIL rand_drain_word: got %h expected %h", out_data, expd); miscompares++;
                    end
                end
            end
            tick();
        end
        vectors++;
        if (sb.size() !== 0 || level !== 8'd0) begin
            $display("FAIL rand_drain_done: got %0d left level=%0d expected 0 0", sb.size(), level); miscompares++;
        end
        out_ready = 1'b0;
        $display("test_random_stalls done");
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 8'(i + 1);
            tick();
        end
        vectors++;
        if (level !== 8'd30) begin
            $display("FAIL mid_fill_level: got %0d expected 30", level); miscompares++;
        end
        in_data = 8'h77;
        rst_n   = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd0 || in_ready !== 1'b1) begin
            $display("FAIL mid_reset: got valid=%b level=%0d in_ready=%b expected 0 0 1",
                     out_valid, level, in_ready); miscompares++;
        end
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL mid_timeout: got no out_valid expected word 5c"); miscompares++;
        end else if (out_data !== 8'h5C) begin
            $display("FAIL mid_first_word: got %h expected 5c", out_data); miscompares++;
        end
        $display("pop word %h after reset", out_data);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || level !== 8'd0) begin
            $display("FAIL mid_after: got valid=%b level=%0d expected 0 0", out_valid, level); miscompares++;
        end
        out_ready = 1'b0;
        $display("test_reset_midstream done");
    endtask

`ifdef RAM_FIFO_WATERMARK_EN
    task automatic test_watermark();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 55; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (level !== 8'd55 || almost_full !== 1'b0) begin
            $display("FAIL af_55: got level=%0d af=%b expected 55 0", level, almost_full); miscompares++;
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (level !== 8'd56 || almost_full !== 1'b1) begin
            $display("FAIL af_56: got level=%0d af=%b expected 56 1", level, almost_full); miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (level !== 8'd55 || almost_full !== 1'b0) begin
            $display("FAIL af_back_55: got level=%0d af=%b expected 55 0", level, almost_full); miscompares++;
        end
        $display("test_watermark done");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = 8'h00;
        test_reset();
        test_fall_through();
        test_fill_drain();
        test_back_to_back();
        test_random_stalls();
        test_reset_midstream();
`ifdef RAM_FIFO_WATERMARK_EN
        test_watermark();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
